// File: rtl/fifo_arb_ctrl.sv
// FIFO controller with an external memory and two write sources arbitrated round-robin.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ARB_ERR_FLAGS_EN.
module fifo_arb_ctrl #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3,
    parameter int AFULL_LVL  = 6,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iPush0,
    input  logic                  iPush1,
    input  logic [DATA_WIDTH-1:0] iData0,
    input  logic [DATA_WIDTH-1:0] iData1,
    input  logic                  iPop,
    input  logic                  iFlush,
    output logic                  oGrant0,
    output logic                  oGrant1,
    output logic                  oMemWriteEnable,
    output logic [ADDR_WIDTH-1:0] oMemWriteAddress,
    output logic [DATA_WIDTH-1:0] oMemDataIn,
    output logic                  oMemReadEnable,
    output logic [ADDR_WIDTH-1:0] oMemReadAddress,
    output logic [ADDR_WIDTH:0]   oCount,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic                  oAlmostFull,
    output logic                  oAlmostEmpty,
    output logic                  oOverflow,
    output logic                  oUnderflow
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF    = AFULL_LVL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE    = AEMPTY_LVL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  rr;
    logic                  wr_ok, rd_ok, wr, rd;

    assign oFull        = (count == DEPTH);
    assign oEmpty       = (count == '0);
    assign oAlmostFull  = (count >= AF);
    assign oAlmostEmpty = (count <= AE);
    assign oCount       = count;

    // Reset gates the grants so nothing reaches memory while it is held.
    always_comb begin
        wr_ok   = !Reset && !iFlush && !oFull;
        rd_ok   = !Reset && !iFlush && !oEmpty;
        oGrant0 = wr_ok && iPush0 && (!iPush1 || !rr);
        oGrant1 = wr_ok && iPush1 && (!iPush0 || rr);
        wr      = oGrant0 || oGrant1;
        rd      = rd_ok && iPop;
    end

    assign oMemWriteEnable  = wr;
    assign oMemWriteAddress = wptr;
    assign oMemDataIn       = oGrant1 ? iData1 : iData0;
    assign oMemReadEnable   = rd;
    assign oMemReadAddress  = rptr;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rr    <= 1'b0;
        end else if (iFlush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Priority only moves when both sources competed for a slot.
            if (wr && iPush0 && iPush1) rr <= ~rr;
        end
    end

`ifdef FIFO_ARB_ERR_FLAGS_EN
    logic ovf, unf;
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if ((iPush0 || iPush1) && oFull) ovf <= 1'b1;
            if (iPop && oEmpty)              unf <= 1'b1;
        end
    end
    assign oOverflow  = ovf;
    assign oUnderflow = unf;
`else
    assign oOverflow  = 1'b0;
    assign oUnderflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Directed bench for fifo_arb_ctrl: queue-based reference model checked every cycle,
// plus hand-computed literal expectations along the directed sequence.
module tb_fifo_arb_ctrl;
    localparam int DW = 6;
    localparam int AW = 3;
    localparam int DEPTH = 8;
`ifdef FIFO_ARB_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Reset, iPush0, iPush1, iPop, iFlush;
    logic [DW-1:0] iData0, iData1;
    logic          oGrant0, oGrant1, oMemWriteEnable, oMemReadEnable;
    logic [AW-1:0] oMemWriteAddress, oMemReadAddress;
    logic [DW-1:0] oMemDataIn, rdata;
    logic [AW:0]   oCount;
    logic          oFull, oEmpty, oAlmostFull, oAlmostEmpty, oOverflow, oUnderflow;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    fifo_arb_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LVL(6), .AEMPTY_LVL(1)) dut (
        .Clock(Clock), .Reset(Reset),
        .iPush0(iPush0), .iPush1(iPush1), .iData0(iData0), .iData1(iData1),
        .iPop(iPop), .iFlush(iFlush),
        .oGrant0(oGrant0), .oGrant1(oGrant1),
        .oMemWriteEnable(oMemWriteEnable), .oMemWriteAddress(oMemWriteAddress),
        .oMemDataIn(oMemDataIn),
        .oMemReadEnable(oMemReadEnable), .oMemReadAddress(oMemReadAddress),
        .oCount(oCount), .oFull(oFull), .oEmpty(oEmpty),
        .oAlmostFull(oAlmostFull), .oAlmostEmpty(oAlmostEmpty),
        .oOverflow(oOverflow), .oUnderflow(oUnderflow)
    );

    // External memory with combinational read.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge Clock) if (oMemWriteEnable) mem[oMemWriteAddress] <= oMemDataIn;
    assign rdata = mem[oMemReadAddress];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, addresses as operation counts mod depth.
    logic [DW-1:0] q[$];
    int  m_wptr, m_rptr;
    bit  m_rr, m_ovf, m_unf, model_on = 1'b0;
    bit  e_full, e_empty, e_g0, e_g1, e_pop;

    always @(negedge Clock) begin
        if (model_on) begin
            e_full  = (q.size() == DEPTH);
            e_empty = (q.size() == 0);
            e_g0 = !Reset && !iFlush && !e_full && iPush0 && (!iPush1 || !m_rr);
            e_g1 = !Reset && !iFlush && !e_full && iPush1 && (!iPush0 || m_rr);
            e_pop = !Reset && !iFlush && !e_empty && iPop;
            chk("m_grant0", oGrant0, e_g0);
            chk("m_grant1", oGrant1, e_g1);
            chk("m_we", oMemWriteEnable, e_g0 | e_g1);
            chk("m_re", oMemReadEnable, e_pop);
            chk("m_count", oCount, q.size());
            chk("m_full", oFull, e_full);
            chk("m_empty", oEmpty, e_empty);
            chk("m_afull", oAlmostFull, q.size() >= 6);
            chk("m_aempty", oAlmostEmpty, q.size() <= 1);
            chk("m_ovf", oOverflow, m_ovf);
            chk("m_unf", oUnderflow, m_unf);
            if (e_g0 || e_g1) begin
                chk("m_waddr", oMemWriteAddress, m_wptr);
                chk("m_wdata", oMemDataIn, e_g1 ? iData1 : iData0);
            end
            if (e_pop) begin
                chk("m_raddr", oMemReadAddress, m_rptr);
                chk("m_rdata", rdata, q[0]);
            end
            if (Reset) begin
                q.delete();
                m_wptr = 0; m_rptr = 0; m_rr = 0; m_ovf = 0; m_unf = 0;
            end else begin
                if (ERR_EN && (iPush0 || iPush1) && e_full) m_ovf = 1;
                if (ERR_EN && iPop && e_empty) m_unf = 1;
                if (iFlush) begin
                    q.delete();
                    m_wptr = 0; m_rptr = 0;
                end else begin
                    if (e_pop) begin
                        void'(q.pop_front());
                        m_rptr = (m_rptr + 1) % DEPTH;
                    end
                    if (e_g0 || e_g1) begin
                        q.push_back(e_g1 ? iData1 : iData0);
                        m_wptr = (m_wptr + 1) % DEPTH;
                        if (iPush0 && iPush1) m_rr = !m_rr;
                    end
                end
            end
        end
    end

    task automatic set_in(input bit p0, input int d0, input bit p1, input int d1,
                          input bit pop, input bit fl);
        iPush0 = p0; iData0 = d0[DW-1:0];
        iPush1 = p1; iData1 = d1[DW-1:0];
        iPop = pop;  iFlush = fl;
        #1;
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_empty"}, oEmpty, 1);
        chk({tag, "_aempty"}, oAlmostEmpty, 1);
        chk({tag, "_full"}, oFull, 0);
        chk({tag, "_afull"}, oAlmostFull, 0);
        chk({tag, "_count"}, oCount, 0);
        chk({tag, "_ovf"}, oOverflow, 0);
        chk({tag, "_unf"}, oUnderflow, 0);
    endtask

    initial begin
        Reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        tick;
        model_on = 1'b1;
        tick; tick;
        Reset = 1'b0;
        #1;
        check_reset_state("rst");

        // Fill from source 0 with 1..8.
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1, i + 1, 0, 0, 0, 0);
            chk("fill_grant0", oGrant0, 1);
            chk("fill_waddr", oMemWriteAddress, i);
            tick;
            chk("fill_count", oCount, i + 1);
            chk("fill_afull", oAlmostFull, (i + 1) >= 6);
        end
        chk("full_flag", oFull, 1);
        set_in(1, 9, 0, 0, 0, 0);
        chk("ovf_grant0", oGrant0, 0);
        tick;
        chk("ovf_flag", oOverflow, ERR_EN);
        chk("ovf_count", oCount, 8);

        // Drain: addresses 0..7, data 1..8.
        for (int i = 0; i < DEPTH; i++) begin
            set_in(0, 0, 0, 0, 1, 0);
            chk("drain_re", oMemReadEnable, 1);
            chk("drain_raddr", oMemReadAddress, i);
            chk("drain_data", rdata, i + 1);
            tick;
        end
        chk("drain_empty", oEmpty, 1);
        set_in(0, 0, 0, 0, 1, 0);
        chk("unf_re", oMemReadEnable, 0);
        tick;
        chk("unf_flag", oUnderflow, ERR_EN);
        chk("sticky_ovf", oOverflow, ERR_EN);

        // Reset, then both sources contend for 4 cycles.
        Reset = 1'b1;
        set_in(1, 0, 1, 0, 1, 1);
        chk("rst_grant0", oGrant0, 0);
        chk("rst_grant1", oGrant1, 0);
        chk("rst_re", oMemReadEnable, 0);
        tick;
        Reset = 1'b0;
        #1;
        check_reset_state("rst2");
        for (int i = 0; i < 4; i++) begin
            set_in(1, 10 + i, 1, 20 + i, 0, 0);
            chk("rr_grant0", oGrant0, (i % 2) == 0);
            chk("rr_grant1", oGrant1, (i % 2) == 1);
            tick;
        end
        chk("rr_count", oCount, 4);

        // Drop to 3, then 20 push+pop cycles across the pointer wrap.
        set_in(0, 0, 0, 0, 1, 0);
        chk("pre_data", rdata, 10);
        tick;
        for (int i = 0; i < 20; i++) begin
            set_in(1, 30 + i, 0, 0, 1, 0);
            tick;
        end
        chk("steady_count", oCount, 3);
        // Last three writes were 47,48,49; oldest one is next out.
        set_in(0, 0, 0, 0, 0, 0);
        chk("steady_head", rdata, 47);

        // Grow to 5, then flush with a push pending.
        set_in(1, 50, 0, 0, 0, 0); tick;
        set_in(1, 51, 0, 0, 0, 0); tick;
        chk("preflush_count", oCount, 5);
        set_in(1, 52, 0, 0, 0, 1);
        chk("flush_grant0", oGrant0, 0);
        chk("flush_we", oMemWriteEnable, 0);
        tick;
        chk("flush_count", oCount, 0);
        chk("flush_empty", oEmpty, 1);

        // Push and pop while empty: only the push lands.
        set_in(1, 60, 0, 0, 1, 0);
        chk("ep_grant0", oGrant0, 1);
        chk("ep_re", oMemReadEnable, 0);
        tick;
        chk("ep_count", oCount, 1);
        set_in(1, 61, 1, 62, 0, 0); tick;
        set_in(1, 63, 1, 0, 1, 0); tick;

        // Reset mid-stream.
        Reset = 1'b1;
        set_in(1, 1, 1, 2, 1, 0);
        chk("mid_grant0", oGrant0, 0);
        chk("mid_grant1", oGrant1, 0);
        chk("mid_we", oMemWriteEnable, 0);
        chk("mid_re", oMemReadEnable, 0);
        tick;
        Reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        check_reset_state("mid");
        tick; tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
